// File: rtl/bitwise_accum_pkg.sv
//------------------------------------------------------------------------------
// Module   : bitwise_accum_pkg
// Brief    : Operation/state encodings and identity fill for bitwise_accum.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bitwise_accum_pkg;

  localparam logic [1:0] OP_OR   = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ACCUM = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  // Single fill bit, replicated by the caller to any width: only AND starts from all-ones.
  function automatic logic identity(input logic [1:0] op);
    return (op == OP_AND);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bitwise_lane.sv
//------------------------------------------------------------------------------
// Module   : bitwise_lane
// Brief    : Combinational per-lane OR/AND/XOR/LOAD of two WIDTH-bit words.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bitwise_lane
  import bitwise_accum_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = b;
    case (op)
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: y = b;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bitwise_accum.sv
//------------------------------------------------------------------------------
// Module   : bitwise_accum
// Brief    : Handshaked accumulator folding len operands with OR/AND/XOR/LOAD.
//            Optional set-bit count output when BITWISE_ACCUM_POPCOUNT_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bitwise_accum
  import bitwise_accum_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEN_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  output logic             start_ready,
  input  logic [1:0]       op,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef BITWISE_ACCUM_POPCOUNT_EN
  output logic [$clog2(WIDTH+1)-1:0] out_ones,
`endif
  output logic             busy
);

  state_t             r_state;
  state_t             w_state_next;
  logic [1:0]         r_op;
  logic [LEN_W-1:0]   r_remaining;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]   w_lane_y;
  logic               w_last_beat;

  bitwise_lane #(.WIDTH(WIDTH)) u_lane (
    .op (r_op),
    .a  (r_acc),
    .b  (in_data),
    .y  (w_lane_y)
  );

  assign w_last_beat = in_valid && (r_remaining == LEN_W'(1));

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    if (!abort) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_acc_next   = {WIDTH{identity(op)}};
            w_state_next = (len == '0) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            w_acc_next = w_lane_y;
            if (w_last_beat) w_state_next = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) w_state_next = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end else begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_op        <= OP_OR;
      r_remaining <= '0;
      r_acc       <= '0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      if (abort) begin
        r_remaining <= '0;
      end else if (r_state == S_IDLE && start) begin
        r_op        <= op;
        r_remaining <= len;
      end else if (r_state == S_ACCUM && in_valid) begin
        r_remaining <= r_remaining - LEN_W'(1);
      end
    end
  end

  assign start_ready = (r_state == S_IDLE);
  assign in_ready    = (r_state == S_ACCUM);
  assign out_valid   = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign out_data    = r_acc;

`ifdef BITWISE_ACCUM_POPCOUNT_EN
  localparam int ONES_W = $clog2(WIDTH+1);
  logic [ONES_W-1:0] w_ones;
  logic [ONES_W-1:0] r_ones;

  always_comb begin
    w_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ones = w_ones + ONES_W'(w_acc_next[i]);
    end
  end

  // Captured only on entry to DONE; any exit (handshake or abort) clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ones <= '0;
    end else if (w_state_next == S_DONE) begin
      if (r_state != S_DONE) r_ones <= w_ones;
    end else begin
      r_ones <= '0;
    end
  end

  assign out_ones = r_ones;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bitwise_accum.sv
//------------------------------------------------------------------------------
// Module   : tb_bitwise_accum
// Brief    : Scoreboard bench for bitwise_accum with directed vectors.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bitwise_accum;

  localparam int WIDTH = 32;
  localparam int LEN_W = 4;
  localparam logic [1:0] C_OR   = 2'b00;
  localparam logic [1:0] C_AND  = 2'b01;
  localparam logic [1:0] C_XOR  = 2'b10;
  localparam logic [1:0] C_LOAD = 2'b11;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             start;
  logic             start_ready;
  logic [1:0]       op;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
`ifdef BITWISE_ACCUM_POPCOUNT_EN
  logic [$clog2(WIDTH+1)-1:0] out_ones;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               ones;
  } exp_t;
  exp_t sb[$];

  bitwise_accum #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .start_ready (start_ready),
    .op          (op),
    .len         (len),
    .abort       (abort),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
`ifdef BITWISE_ACCUM_POPCOUNT_EN
    .out_ones    (out_ones),
`endif
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // Compares the head of the scoreboard every cycle a result is presented; pops on handshake.
  always @(negedge clock) begin
    if (reset_n && out_valid) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out_valid: out_data=%h, none expected", out_data);
      end else begin
        if (out_data !== sb[0].data) begin
          n_fail++;
          $display("FAIL out_data: got %h expected %h", out_data, sb[0].data);
        end
`ifdef BITWISE_ACCUM_POPCOUNT_EN
        n_tests++;
        if (int'(out_ones) != sb[0].ones) begin
          n_fail++;
          $display("FAIL out_ones: got %0d expected %0d", out_ones, sb[0].ones);
        end
`endif
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input int ones);
    exp_t e;
    e.data = d;
    e.ones = ones;
    sb.push_back(e);
  endtask

  task automatic wait_start_ready();
    int k = 0;
    while (!start_ready && k < 50) begin
      @(posedge clock); #1;
      k++;
    end
    if (!start_ready) check("start_ready_timeout", {31'd0, start_ready}, 32'd1);
  endtask

  task automatic start_txn(input logic [1:0] o, input logic [LEN_W-1:0] l);
    wait_start_ready();
    start = 1'b1;
    op    = o;
    len   = l;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    int k = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && k < 50) begin
      @(posedge clock); #1;
      k++;
    end
    if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    op        = C_OR;
    len       = '0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Reset values
    check("rst_out_valid",   {31'd0, out_valid},   32'd0);
    check("rst_start_ready", {31'd0, start_ready}, 32'd1);
    check("rst_in_ready",    {31'd0, in_ready},    32'd0);
    check("rst_busy",        {31'd0, busy},        32'd0);
    check("rst_out_data",    out_data,             32'd0);

    // OR len=3, result held under back-pressure
    out_ready = 1'b0;
    push(32'h8000_00FF, 9);
    start_txn(C_OR, 4'd3);
    check("or_in_ready_after_start", {31'd0, in_ready}, 32'd1);
    send(32'h0000_000F);
    send(32'h0000_00F0);
    send(32'h8000_0000);
    check("or_latency_out_valid", {31'd0, out_valid}, 32'd1);
    repeat (5) @(posedge clock);
    #1 check("or_held_out_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    wait_start_ready();

    // AND len=2
    push(32'h0F0F_0F0F, 16);
    start_txn(C_AND, 4'd2);
    send(32'hFFFF_0F0F);
    send(32'h0F0F_FFFF);
    wait_start_ready();

    // XOR len=2
    push(32'h0000_0000, 0);
    start_txn(C_XOR, 4'd2);
    send(32'hAAAA_AAAA);
    send(32'hAAAA_AAAA);
    wait_start_ready();

    // len=0 AND: identity straight to DONE
    push(32'hFFFF_FFFF, 32);
    start_txn(C_AND, 4'd0);
    check("len0_out_valid", {31'd0, out_valid}, 32'd1);
    check("len0_no_in_ready", {31'd0, in_ready}, 32'd0);
    wait_start_ready();

    // LOAD len=4 with gaps and ignored start pulse
    push(32'h1234_5678, 13);
    start_txn(C_LOAD, 4'd4);
    send(32'hDEAD_BEEF);
    start = 1'b1; op = C_AND; len = 4'd0;
    @(posedge clock); #1;
    start = 1'b0;
    check("start_ignored_busy",     {31'd0, busy},     32'd1);
    check("start_ignored_in_ready", {31'd0, in_ready}, 32'd1);
    send(32'h0000_1111);
    @(posedge clock); #1;
    send(32'hCAFE_F00D);
    @(posedge clock); #1;
    send(32'h1234_5678);
    wait_start_ready();

    // Abort coincident with the final beat
    start_txn(C_OR, 4'd2);
    send(32'h0000_00F0);
    in_valid = 1'b1; in_data = 32'h0000_0002; abort = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; abort = 1'b0;
    check("abort_start_ready", {31'd0, start_ready}, 32'd1);
    check("abort_out_valid",   {31'd0, out_valid},   32'd0);
    repeat (3) @(posedge clock);

    // Abort together with start in IDLE keeps the block idle
    #1 start = 1'b1; abort = 1'b1; op = C_OR; len = 4'd1;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_start_idle", {31'd0, start_ready}, 32'd1);

    push(32'h0000_0001, 1);
    start_txn(C_OR, 4'd1);
    send(32'h0000_0001);
    wait_start_ready();

    // Asynchronous reset mid-ACCUM discards the partial result
    start_txn(C_OR, 4'd4);
    send(32'h0000_00F0);
    send(32'h0F00_0000);
    reset_n = 1'b0;
    #2;
    check("midrst_out_valid",   {31'd0, out_valid},   32'd0);
    check("midrst_start_ready", {31'd0, start_ready}, 32'd1);
    check("midrst_out_data",    out_data,             32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    repeat (5) @(posedge clock);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
